// File: rtl/inv_fact_pkg.sv
// Shared types and sizing for the inverse-factorial decoder.
// Search runs over n = 1..MAX_N with a running factorial product.
package inv_fact_pkg;

  localparam int MAX_N = 12;
  localparam int ACC_W = 36;
  localparam int N_W   = 4;
  localparam int V_W   = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

endpackage

// File: rtl/inv_fact_step.sv
// Combinational step of the factorial search: next product and the
// comparisons that decide whether the search stops at the current k.
module inv_fact_step
  import inv_fact_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [N_W-1:0]   k,
  input  logic [V_W-1:0]   v,
  output logic [ACC_W-1:0] prod,
  output logic             eq,
  output logic             over,
  output logic             at_max
);

  logic [ACC_W-1:0] kp1;
  logic [ACC_W-1:0] v_ext;

  assign kp1    = ACC_W'(k) + ACC_W'(1);
  assign v_ext  = ACC_W'(v);
  // acc never exceeds 12!, so the 36-bit product of acc*(k+1) cannot wrap
  assign prod   = acc * kp1;
  assign eq     = (acc == v_ext);
  assign over   = (prod > v_ext);
  assign at_max = (k == N_W'(MAX_N));

endmodule

// File: rtl/inv_factorial.sv
// Decodes a (optionally doubled) factorial value back to n, reporting
// the floor n and whether the value matched exactly.
module inv_factorial
  import inv_fact_pkg::*;
#(
  parameter int PRESCALED = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [V_W-1:0] in_value,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] out_n,
  output logic           out_exact,
  output logic           busy
);

  state_t           state_q, state_d;
  logic [N_W-1:0]   k_q, k_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             exact_q, exact_d;
  logic [V_W-1:0]   v_q, v_in;
  logic             odd_q, odd_in;
  logic             accept;
  logic [ACC_W-1:0] prod;
  logic             eq, over, at_max;

  assign v_in   = (PRESCALED != 0) ? {1'b0, in_value[V_W-1:1]} : in_value;
  assign odd_in = (PRESCALED != 0) && in_value[0];
  assign accept = in_valid && (state_q == S_IDLE);

  inv_fact_step u_step (
    .acc    (acc_q),
    .k      (k_q),
    .v      (v_q),
    .prod   (prod),
    .eq     (eq),
    .over   (over),
    .at_max (at_max)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    n_d     = n_q;
    exact_d = exact_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SEARCH;
          k_d     = N_W'(1);
          acc_d   = ACC_W'(1);
        end
      end
      S_SEARCH: begin
        if (v_q == '0) begin
          state_d = S_DONE;
          n_d     = '0;
          exact_d = !odd_q;
        end else if (eq) begin
          state_d = S_DONE;
          n_d     = k_q;
          exact_d = !odd_q;
        end else if (over || at_max) begin
          state_d = S_DONE;
          n_d     = k_q;
          exact_d = 1'b0;
        end else begin
          k_d     = k_q + N_W'(1);
          acc_d   = prod;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= N_W'(1);
      acc_q   <= ACC_W'(1);
      n_q     <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      exact_q <= exact_d;
    end
  end

  // Search operand is captured once at acceptance and ignored afterwards
  always_ff @(posedge clk) begin
    if (accept) begin
      v_q   <= v_in;
      odd_q <= odd_in;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_SEARCH);
  assign out_valid = (state_q == S_DONE);
  assign out_n     = n_q;
  assign out_exact = exact_q;

endmodule

// File: tb/tb_inv_factorial.sv
// Scoreboard bench for inv_factorial: one instance per PRESCALED setting,
// randomized values checked against a factorial-table reference model.
module tb_inv_factorial;

  typedef struct {
    logic [3:0] n;
    logic       exact;
    int         acc_cyc;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset     [2];
  logic        in_valid  [2];
  logic [31:0] in_value  [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [3:0]  out_n     [2];
  logic        out_exact [2];
  logic        busy      [2];
  bit          bp_hold   [2];

  exp_t sbq [2][$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint got, longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic longint fact(int n);
    longint f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Largest n in 1..12 with n! <= v; v==0 decodes to 0.
  function automatic exp_t ref_model(logic [31:0] x, bit pre);
    exp_t   e;
    longint v;
    bit     odd;
    v   = pre ? longint'(x >> 1) : longint'(x);
    odd = pre && x[0];
    e.n = 4'd0;
    e.exact = !odd;
    if (v != 0) begin
      for (int i = 1; i <= 12; i++)
        if (fact(i) <= v) e.n = 4'(i);
      e.exact = (fact(int'(e.n)) == v) && !odd;
    end
    e.lat = (e.n == 4'd0) ? 1 : int'(e.n);
    e.acc_cyc = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    inv_factorial #(.PRESCALED(g)) dut (
      .clk       (clk),
      .reset     (reset[g]),
      .in_valid  (in_valid[g]),
      .in_value  (in_value[g]),
      .in_ready  (in_ready[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_n     (out_n[g]),
      .out_exact (out_exact[g]),
      .busy      (busy[g])
    );

    initial begin
      forever begin
        @(negedge clk);
        if (!bp_hold[g]) out_ready[g] = ($urandom_range(0, 3) != 0);
      end
    end

    initial begin
      bit   seen = 1'b0;
      bit   have = 1'b0;
      exp_t cur;
      forever begin
        @(negedge clk);
        if (out_valid[g]) begin
          check($sformatf("in_ready_low_in_done_d%0d", g), in_ready[g], 0);
          if (!seen) begin
            seen = 1'b1;
            if (sbq[g].size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_out_d%0d: out_valid with nothing pending, out_n %0d required none",
                       g, out_n[g]);
            end else begin
              cur  = sbq[g].pop_front();
              have = 1'b1;
              check($sformatf("out_n_d%0d", g), out_n[g], cur.n);
              check($sformatf("out_exact_d%0d", g), out_exact[g], cur.exact);
              check($sformatf("latency_d%0d", g), cyc - cur.acc_cyc, cur.lat);
            end
          end else if (have) begin
            check($sformatf("out_n_stable_d%0d", g), out_n[g], cur.n);
            check($sformatf("out_exact_stable_d%0d", g), out_exact[g], cur.exact);
          end
        end else begin
          seen = 1'b0;
          have = 1'b0;
        end
      end
    end
  end

  task automatic send(int g, logic [31:0] val, bit push);
    int   t = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready[g] && t < 300) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("in_ready_wait_d%0d", g), in_ready[g], 1);
    if (!in_ready[g]) return;
    in_valid[g] = 1'b1;
    in_value[g] = val;
    @(posedge clk);
    #1;
    e = ref_model(val, g == 1);
    e.acc_cyc = cyc;
    if (push) sbq[g].push_back(e);
    in_valid[g] = 1'b0;
    in_value[g] = $urandom;
  endtask

  task automatic drain(int g);
    int t = 0;
    while ((sbq[g].size() != 0 || !in_ready[g]) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("drain_d%0d", g), sbq[g].size(), 0);
  endtask

  task automatic check_reset_state(int g, string tag);
    check($sformatf("%s_in_ready_d%0d", tag, g), in_ready[g], 1);
    check($sformatf("%s_out_valid_d%0d", tag, g), out_valid[g], 0);
    check($sformatf("%s_busy_d%0d", tag, g), busy[g], 0);
    check($sformatf("%s_out_n_d%0d", tag, g), out_n[g], 0);
    check($sformatf("%s_out_exact_d%0d", tag, g), out_exact[g], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v1 [9];
    logic [31:0] v0 [7];
    logic [31:0] val;
    int          n;
    int          t;
    v1 = '{32'd240, 32'd241, 32'd0, 32'd1, 32'd958003200, 32'hFFFFFFFF, 32'd2, 32'd3, 32'd4};
    v0 = '{32'd720, 32'd721, 32'd1, 32'd0, 32'd479001600, 32'hFFFFFFFF, 32'd2};
    for (int g = 0; g < 2; g++) begin
      reset[g] = 1'b1;
      in_valid[g] = 1'b0;
      in_value[g] = '0;
      bp_hold[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) check_reset_state(g, "por");
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    foreach (v1[i]) send(1, v1[i], 1'b1);
    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(1, 12));
      case ($urandom_range(0, 2))
        0: val = $urandom;
        1: val = 32'(2 * fact(n) + longint'($urandom_range(0, 1)));
        default: val = 32'(2 * fact(n) + longint'($urandom_range(0, 32'(2 * fact(n)))));
      endcase
      send(1, val, 1'b1);
    end
    drain(1);

    foreach (v0[i]) send(0, v0[i], 1'b1);
    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(1, 12));
      case ($urandom_range(0, 2))
        0: val = $urandom;
        1: val = 32'(fact(n) + longint'($urandom_range(0, 1)));
        default: val = 32'(fact(n) + longint'($urandom_range(0, 32'(fact(n)))));
      endcase
      send(0, val, 1'b1);
    end
    drain(0);

    // backpressure: result held in DONE while in_valid toggles
    @(posedge clk);
    #1;
    bp_hold[1] = 1'b1;
    out_ready[1] = 1'b0;
    send(1, 32'd240, 1'b1);
    t = 0;
    @(negedge clk);
    while (!out_valid[1] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_out_valid_seen", out_valid[1], 1);
    for (int i = 0; i < 3; i++) begin
      in_valid[1] = 1'b1;
      in_value[1] = $urandom;
      @(negedge clk);
    end
    check("bp_still_done", out_valid[1], 1);
    check("bp_busy_low", busy[1], 0);
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_handshake_out_valid", out_valid[1], 0);
    check("bp_handshake_in_ready", in_ready[1], 1);
    check("bp_no_accept", busy[1], 0);
    bp_hold[1] = 1'b0;
    drain(1);

    // reset in the third SEARCH cycle discards the result
    send(1, 32'd240, 1'b0);
    @(negedge clk);
    check("rst_busy_search1", busy[1], 1);
    @(negedge clk);
    @(negedge clk);
    check("rst_busy_search3", busy[1], 1);
    reset[1] = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state(1, "midrst");
    @(negedge clk);
    reset[1] = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_idle_after", in_ready[1], 1);
    send(1, 32'd240, 1'b1);
    drain(1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
